chan_serializer: RTL and testbench
==================================

Name: chan_serializer

Overview:
- Parametrised channel serializer feeding the receive FIFO: on each sample strobe it snapshots NCH parallel WIDTH-bit channel words, then writes the first channels+1 of them, one word per clock, into the FIFO write port.
- Improvements over the previous channel select/mux pair: input snapshot, so the data cannot change mid-frame; downstream back-pressure (hold); back-to-back frames with no idle gap; overrun detection; frame markers.

Parameters:
- NCH, 8, number of physical channel inputs (2..16).
- WIDTH, 16, bits per channel word.
- CW, 3, width of the channels/select field; must be at least clog2(NCH).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  enable; while low, new frames are not started.
- strobe  input  1  sample strobe; one-cycle pulse per sample period.
- channels  input  CW  active channel count minus 1; sampled at frame start.
- hold  input  1  downstream full; stalls word emission.
- din  input  NCH*WIDTH  packed channel words; channel k is din[k*WIDTH +: WIDTH].
- dout  output  WIDTH  registered output word.
- req_data  output  1  registered write strobe; one-cycle high per word.
- first  output  1  high with req_data on the channel-0 word of each frame.
- frame_done  output  1  high with req_data on the last word of each frame.
- busy  output  1  high while a frame is pending or being emitted.
- overrun  output  1  sticky flag: a strobe was dropped.
- drop_cnt  output  8  saturating count of dropped strobes.

Behaviour:
- Reset, asynchronous and immediate (also mid-frame):
  - all outputs go to 0, the FSM goes to IDLE, sel goes to 0.
  - The partial frame is discarded; no further req_data follows reset release until a new strobe arrives.
- Internal state: snap (NCH*WIDTH), nlast (CW), sel (CW), FSM {IDLE, SEND}.
- Clamp rule: nlast <= min(channels, NCH-1), latched at frame start. Changes to channels mid-frame have no effect.
- IDLE:
  - At an edge with strobe && en: snap <= din, nlast <= clamp(channels), sel <= 0, go to SEND, busy <= 1.
  - Otherwise stay in IDLE with req_data = 0.
- SEND, edge with hold = 0:
  - req_data <= 1, dout <= snap[sel], first <= (sel == 0), frame_done <= (sel == nlast).
  - If sel != nlast: sel <= sel+1.
  - If sel == nlast and strobe && en at this same edge: back-to-back start. Re-latch snap, nlast, sel <= 0, stay in SEND. Zero idle cycles between frames.
  - If sel == nlast with no new strobe: go to IDLE, busy <= 0.
- SEND, edge with hold = 1:
  - req_data, first and frame_done <= 0; dout, sel and snap hold.
- Latency: strobe sampled at edge t gives the channel-0 word with req_data high after edge t+1. A frame with nlast = n emits n+1 words in n+1 unstalled cycles.
- Overrun: strobe && en at an edge in SEND that is not a back-to-back start (including any hold cycle) causes:
  - the strobe is dropped;
  - overrun <= 1;
  - drop_cnt <= drop_cnt+1, saturating at 255.
  - The current frame is unaffected.
- Clearing: overrun and drop_cnt clear only on reset or on an edge with en = 0.
- en low mid-frame: the current frame completes normally and no new frame starts. Strobes with en = 0 are ignored and not counted.
- Between words, dout retains the last emitted word.

Test Plan:
1. Reset; channels=3, din ch k = 16'h1000+k; strobe at edge 5 -> req_data high after edges 6..9 with dout 1000,1001,1002,1003; first on 1000; frame_done on 1003; busy low after edge 9.
2. channels=7, strobe every 8 cycles for 4 frames -> 32 contiguous req_data cycles, ch0..ch7 repeating, overrun=0, drop_cnt=0.
3. channels=2, hold=1 for 3 cycles after the second word -> words 0,1, then 3 cycles with req_data=0 and dout holding ch1, then word 2 with frame_done; snap unchanged even though din changed during the stall.
4. channels=7, strobe every 4 cycles -> every second strobe dropped; overrun=1, drop_cnt increments per drop; pulsing en=0 for 1 cycle clears both to 0.
5. NCH=6, CW=3, channels=7 -> clamped to 6 words (ch0..ch5); frame_done on ch5.
6. Assert reset during word 2 of an 8-word frame -> all outputs 0 immediately; after release no req_data until the next strobe; the next frame starts at ch0.

Source files
------------

// File: rtl/chan_serializer.sv
// Channel serializer: snapshots NCH parallel channel words on a sample strobe and
// writes the first channels+1 of them, one word per clock, into the receive FIFO.
module chan_serializer #(
    parameter int NCH   = 8,
    parameter int WIDTH = 16,
    parameter int CW    = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 strobe,
    input  logic [CW-1:0]        channels,
    input  logic                 hold,
    input  logic [NCH*WIDTH-1:0] din,
    output logic [WIDTH-1:0]     dout,
    output logic                 req_data,
    output logic                 first,
    output logic                 frame_done,
    output logic                 busy,
    output logic                 overrun,
    output logic [7:0]           drop_cnt
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    localparam logic [CW-1:0] LAST_MAX = CW'(NCH - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NCH*WIDTH-1:0] r_snap;
    logic [CW-1:0]        r_nlast;
    logic [CW-1:0]        r_sel;
    logic [CW-1:0]        w_nlast_clamp;
    logic [WIDTH-1:0]     w_word;
    logic                 w_go;
    logic                 w_at_last;
    logic                 w_emit;
    logic                 w_start;
    logic                 w_drop;
    logic                 w_advance;

    assign w_go          = strobe & en;
    assign w_at_last     = (r_sel == r_nlast);
    assign w_nlast_clamp = (channels > LAST_MAX) ? LAST_MAX : channels;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_go) w_state_nxt = S_SEND;
            S_SEND:  if (!hold && w_at_last && !w_go) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A strobe landing exactly on the last unstalled word restarts without a gap;
    // any other strobe seen in SEND is dropped.
    always_comb begin
        w_emit    = 1'b0;
        w_start   = 1'b0;
        w_drop    = 1'b0;
        w_advance = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_start = w_go;
            end
            S_SEND: begin
                w_emit    = !hold;
                w_start   = !hold && w_at_last && w_go;
                w_drop    = w_go && !(!hold && w_at_last);
                w_advance = !hold && !w_at_last;
            end
            default: begin
                w_start = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_word = '0;
        for (int k = 0; k < NCH; k++) begin
            if (r_sel == CW'(k)) w_word = r_snap[k*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_snap  <= '0;
            r_nlast <= '0;
            r_sel   <= '0;
        end else if (w_start) begin
            r_snap  <= din;
            r_nlast <= w_nlast_clamp;
            r_sel   <= '0;
        end else if (w_advance) begin
            r_sel   <= r_sel + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout       <= '0;
            req_data   <= 1'b0;
            first      <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            req_data   <= w_emit;
            first      <= w_emit && (r_sel == '0);
            frame_done <= w_emit && w_at_last;
            busy       <= (w_state_nxt == S_SEND);
            if (w_emit) dout <= w_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun  <= 1'b0;
            drop_cnt <= '0;
        end else if (!en) begin
            overrun  <= 1'b0;
            drop_cnt <= '0;
        end else if (w_drop) begin
            overrun <= 1'b1;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_chan_serializer.sv
// Directed bench for chan_serializer: a per-cycle vector table plus hand-written
// sequences for back-to-back frames, overrun/saturation, clamping and mid-frame reset.
module tb_chan_serializer;

    localparam int NCH   = 8;
    localparam int WIDTH = 16;
    localparam int CW    = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 en;
    logic                 strobe;
    logic                 hold;
    logic [CW-1:0]        channels;
    logic [NCH*WIDTH-1:0] din;

    logic [WIDTH-1:0] dout;
    logic             req_data, first, frame_done, busy, overrun;
    logic [7:0]       drop_cnt;

    logic [WIDTH-1:0] d6_dout;
    logic             d6_req, d6_first, d6_done, d6_busy, d6_ovr;
    logic [7:0]       d6_cnt;

    int n_cmp = 0;
    int n_err = 0;

    chan_serializer #(.NCH(NCH), .WIDTH(WIDTH), .CW(CW)) u_dut (
        .clk(clk), .reset(reset), .en(en), .strobe(strobe), .channels(channels),
        .hold(hold), .din(din), .dout(dout), .req_data(req_data), .first(first),
        .frame_done(frame_done), .busy(busy), .overrun(overrun), .drop_cnt(drop_cnt)
    );

    chan_serializer #(.NCH(6), .WIDTH(WIDTH), .CW(3)) u_dut6 (
        .clk(clk), .reset(reset), .en(en), .strobe(strobe), .channels(channels),
        .hold(hold), .din(din[6*WIDTH-1:0]), .dout(d6_dout), .req_data(d6_req),
        .first(d6_first), .frame_done(d6_done), .busy(d6_busy), .overrun(d6_ovr),
        .drop_cnt(d6_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        strobe;
        logic        en;
        logic        hold;
        logic [2:0]  ch;
        logic [15:0] base;
        logic        req;
        logic [15:0] dout;
        logic        first;
        logic        done;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input logic e, input logic h,
                                input logic [2:0] ch, input logic [15:0] base,
                                input logic r, input logic [15:0] d,
                                input logic f, input logic dn, input logic b);
        vec_t v;
        v.strobe = s; v.en = e; v.hold = h; v.ch = ch; v.base = base;
        v.req = r; v.dout = d; v.first = f; v.done = dn; v.busy = b;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic set_din(input logic [15:0] base);
        for (int k = 0; k < NCH; k++) din[k*WIDTH +: WIDTH] = base + 16'(k);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        strobe = 1'b0;
        en     = 1'b1;
        hold   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        channels = 3'd0;
        set_din(16'h0000);
        do_reset();

        check("reset req", {31'd0, req_data}, 32'd0);
        check("reset dout", {16'd0, dout}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset cnt", {24'd0, drop_cnt}, 32'd0);

        // basic 4-word frame, en-gated strobe, then a stalled 3-word frame
        vecs.push_back(mk(1'b1,1'b1,1'b0,3'd3,16'h1000, 1'b0,16'h0000,1'b0,1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b1,1'b0,3'd3,16'h1000, 1'b1,16'h1000,1'b1,1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b1,1'b0,3'd3,16'h1000, 1'b1,16'h1001,1'b0,1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b1,1'b0,3'd3,16'h1000, 1'b1,16'h1002,1'b0,1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b1,1'b0,3'd3,16'h1000, 1'b1,16'h1003,1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,3'd3,16'h1000, 1'b0,16'h1003,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b0,3'd3,16'h1000, 1'b0,16'h1003,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,3'd3,16'h1000, 1'b0,16'h1003,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b1,1'b0,3'd2,16'h2000, 1'b0,16'h1003,1'b0,1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b1,1'b0,3'd2,16'h2000, 1'b1,16'h2000,1'b1,1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b1,1'b0,3'd2,16'h2000, 1'b1,16'h2001,1'b0,1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b1,1'b1,3'd2,16'h3000, 1'b0,16'h2001,1'b0,1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b1,1'b1,3'd5,16'h3000, 1'b0,16'h2001,1'b0,1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b1,1'b1,3'd5,16'h3000, 1'b0,16'h2001,1'b0,1'b0,1'b1));
        vecs.push_back(mk(1'b0,1'b1,1'b0,3'd5,16'h3000, 1'b1,16'h2002,1'b0,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,3'd5,16'h3000, 1'b0,16'h2002,1'b0,1'b0,1'b0));

        foreach (vecs[i]) begin
            strobe   = vecs[i].strobe;
            en       = vecs[i].en;
            hold     = vecs[i].hold;
            channels = vecs[i].ch;
            set_din(vecs[i].base);
            step();
            check($sformatf("v%0d req", i),   {31'd0, req_data},   {31'd0, vecs[i].req});
            check($sformatf("v%0d dout", i),  {16'd0, dout},       {16'd0, vecs[i].dout});
            check($sformatf("v%0d first", i), {31'd0, first},      {31'd0, vecs[i].first});
            check($sformatf("v%0d done", i),  {31'd0, frame_done}, {31'd0, vecs[i].done});
            check($sformatf("v%0d busy", i),  {31'd0, busy},       {31'd0, vecs[i].busy});
        end
        strobe = 1'b0;
        hold   = 1'b0;
        en     = 1'b1;
        check("table ovr", {31'd0, overrun}, 32'd0);

        // back-to-back 8-word frames
        do_reset();
        channels = 3'd7;
        set_din(16'h4000);
        for (int c = 0; c < 34; c++) begin
            strobe = (c % 8 == 0) && (c < 32);
            step();
            check($sformatf("b2b req c%0d", c), {31'd0, req_data}, {31'd0, (c >= 1 && c <= 32)});
            check($sformatf("b2b busy c%0d", c), {31'd0, busy}, {31'd0, (c < 32)});
            if (c >= 1 && c <= 32) begin
                check($sformatf("b2b dout c%0d", c), {16'd0, dout}, 32'h4000 + 32'((c - 1) % 8));
                check($sformatf("b2b first c%0d", c), {31'd0, first}, {31'd0, ((c - 1) % 8 == 0)});
                check($sformatf("b2b done c%0d", c), {31'd0, frame_done}, {31'd0, ((c - 1) % 8 == 7)});
            end
        end
        strobe = 1'b0;
        check("b2b ovr", {31'd0, overrun}, 32'd0);
        check("b2b cnt", {24'd0, drop_cnt}, 32'd0);

        // strobes too fast: every second one dropped
        do_reset();
        channels = 3'd7;
        set_din(16'h7000);
        for (int c = 0; c < 26; c++) begin
            int exp_cnt;
            strobe = (c % 4 == 0) && (c <= 20);
            step();
            exp_cnt = int'(c >= 4) + int'(c >= 12) + int'(c >= 20);
            check($sformatf("ovr cnt c%0d", c), {24'd0, drop_cnt}, 32'(exp_cnt));
            check($sformatf("ovr flag c%0d", c), {31'd0, overrun}, {31'd0, (exp_cnt != 0)});
            check($sformatf("ovr req c%0d", c), {31'd0, req_data}, {31'd0, (c >= 1 && c <= 24)});
        end
        strobe = 1'b0;
        en = 1'b0;
        step();
        check("en clr ovr", {31'd0, overrun}, 32'd0);
        check("en clr cnt", {24'd0, drop_cnt}, 32'd0);
        en = 1'b1;

        // drops during a hold stall, counter saturation
        strobe = 1'b1;
        hold   = 1'b1;
        step();
        for (int i = 0; i < 260; i++) begin
            step();
            if (i == 99) check("sat cnt 100", {24'd0, drop_cnt}, 32'd100);
        end
        check("sat cnt", {24'd0, drop_cnt}, 32'd255);
        check("sat ovr", {31'd0, overrun}, 32'd1);
        check("sat req", {31'd0, req_data}, 32'd0);
        strobe = 1'b0;
        hold   = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("sat last dout", {16'd0, dout}, 32'h7007);
        check("sat last done", {31'd0, frame_done}, 32'd1);
        check("sat busy", {31'd0, busy}, 32'd0);
        check("sat ovr kept", {31'd0, overrun}, 32'd1);
        en = 1'b0;
        step();
        check("sat clr cnt", {24'd0, drop_cnt}, 32'd0);
        en = 1'b1;

        // channel count above NCH-1 clamps on a 6-channel instance
        do_reset();
        channels = 3'd7;
        set_din(16'h5000);
        for (int c = 0; c < 8; c++) begin
            strobe = (c == 0);
            step();
            check($sformatf("clamp req c%0d", c), {31'd0, d6_req}, {31'd0, (c >= 1 && c <= 6)});
            check($sformatf("clamp busy c%0d", c), {31'd0, d6_busy}, {31'd0, (c < 6)});
            if (c >= 1 && c <= 6) begin
                check($sformatf("clamp dout c%0d", c), {16'd0, d6_dout}, 32'h5000 + 32'(c - 1));
                check($sformatf("clamp done c%0d", c), {31'd0, d6_done}, {31'd0, (c == 6)});
            end
        end
        strobe = 1'b0;
        check("clamp ovr", {31'd0, d6_ovr}, 32'd0);
        check("clamp cnt", {24'd0, d6_cnt}, 32'd0);
        check("clamp first", {31'd0, d6_first}, 32'd0);

        // asynchronous reset mid-frame
        do_reset();
        channels = 3'd7;
        set_din(16'h6000);
        strobe = 1'b1; step();
        strobe = 1'b0; step();
        strobe = 1'b1; step();
        strobe = 1'b0; step();
        check("pre-rst dout", {16'd0, dout}, 32'h6002);
        check("pre-rst ovr", {31'd0, overrun}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rst req", {31'd0, req_data}, 32'd0);
        check("rst dout", {16'd0, dout}, 32'd0);
        check("rst first", {31'd0, first}, 32'd0);
        check("rst done", {31'd0, frame_done}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst ovr", {31'd0, overrun}, 32'd0);
        check("rst cnt", {24'd0, drop_cnt}, 32'd0);
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("post-rst req %0d", i), {31'd0, req_data}, 32'd0);
            check($sformatf("post-rst busy %0d", i), {31'd0, busy}, 32'd0);
        end
        set_din(16'h6100);
        strobe = 1'b1; step();
        strobe = 1'b0; step();
        check("restart req", {31'd0, req_data}, 32'd1);
        check("restart dout", {16'd0, dout}, 32'h6100);
        check("restart first", {31'd0, first}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
